// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Passes ALU results through and runs the req/ack data-memory handshake for loads/stores.
// Handles byte-lane steering, byte enables and load sign/zero extension.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses are trapped).
module mem_stage #(
  parameter logic [7:0] ALUOP_LB  = 8'h20,
  parameter logic [7:0] ALUOP_LH  = 8'h21,
  parameter logic [7:0] ALUOP_LW  = 8'h22,
  parameter logic [7:0] ALUOP_LBU = 8'h23,
  parameter logic [7:0] ALUOP_LHU = 8'h24,
  parameter logic [7:0] ALUOP_SB  = 8'h28,
  parameter logic [7:0] ALUOP_SH  = 8'h29,
  parameter logic [7:0] ALUOP_SW  = 8'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] rt_data_i,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic        is_load_c, is_store_c, is_mem_c;
  logic        sz_byte_c, sz_half_c, sign_c;
  logic        mis_c;
  logic [3:0]  be_c;
  logic [31:0] lane_data_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;

  // Decode operation class, access size and signedness
  always_comb begin
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    sz_byte_c  = 1'b0;
    sz_half_c  = 1'b0;
    sign_c     = 1'b0;
    case (aluop_i)
      ALUOP_LB:  begin is_load_c  = 1'b1; sz_byte_c = 1'b1; sign_c = 1'b1; end
      ALUOP_LH:  begin is_load_c  = 1'b1; sz_half_c = 1'b1; sign_c = 1'b1; end
      ALUOP_LW:  begin is_load_c  = 1'b1; end
      ALUOP_LBU: begin is_load_c  = 1'b1; sz_byte_c = 1'b1; end
      ALUOP_LHU: begin is_load_c  = 1'b1; sz_half_c = 1'b1; end
      ALUOP_SB:  begin is_store_c = 1'b1; sz_byte_c = 1'b1; end
      ALUOP_SH:  begin is_store_c = 1'b1; sz_half_c = 1'b1; end
      ALUOP_SW:  begin is_store_c = 1'b1; end
      default:   ;
    endcase
    is_mem_c = is_load_c | is_store_c;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0
  assign mis_c = is_mem_c & ((sz_half_c & addr_i[0]) |
                             (~sz_byte_c & ~sz_half_c & (addr_i[1:0] != 2'b00)));
`else
  assign mis_c = 1'b0;
`endif

  // Byte enables and lane-replicated store data by access size
  always_comb begin
    be_c        = 4'b1111;
    lane_data_c = rt_data_i;
    if (sz_byte_c) begin
      be_c        = 4'b0001 << addr_i[1:0];
      lane_data_c = {4{rt_data_i[7:0]}};
    end else if (sz_half_c) begin
      be_c        = addr_i[1] ? 4'b1100 : 4'b0011;
      lane_data_c = {2{rt_data_i[15:0]}};
    end
  end

  // Select the addressed lane of the captured load data and extend it
  always_comb begin
    byte_c = 8'(rdata_q >> {addr_i[1:0], 3'b000});
    half_c = addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (sz_byte_c)
      load_c = sign_c ? {{24{byte_c[7]}}, byte_c} : {24'b0, byte_c};
    else if (sz_half_c)
      load_c = sign_c ? {{16{half_c[15]}}, half_c} : {16'b0, half_c};
    else
      load_c = rdata_q;
  end

  // State, captured load data and trap flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and stage outputs
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    we_o       = we_i;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        misalign_d = mis_c;
        if (is_mem_c) begin
          stall_o    = 1'b1;
          misalign_o = mis_c;
          if (mis_c) begin
            state_d = DONE;
          end else begin
            dmem_req_o = 1'b1;
            if (dmem_ack_i) begin
              state_d = DONE;
              rdata_d = dmem_rdata_i;
            end else begin
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          state_d = DONE;
          rdata_d = dmem_rdata_i;
        end
      end
      DONE: begin
        state_d    = IDLE;
        misalign_o = misalign_q;
        if (misalign_q)
          we_o = 1'b0;
        else if (is_load_c)
          wdata_o = load_c;
      end
      default: state_d = IDLE;
    endcase
    if (stall_o)
      we_o = 1'b0;
  end

  // Data-memory port drive; address and lanes are stable while EX/MEM is frozen
  assign waddr_o      = waddr_i;
  assign dmem_we_o    = dmem_req_o & is_store_c;
  assign dmem_addr_o  = {addr_i[31:2], 2'b00};
  assign dmem_be_o    = be_c;
  assign dmem_wdata_o = lane_data_c;

endmodule
